// File: rtl/card_edges.sv
// Scans outward from a centre point through a 2-cycle-latency pixel buffer and reports the card's four edges.
// Optional EDGES_DEBOUNCE_EN: an edge needs two consecutive background pixels instead of one.
module card_edges #(
   parameter int HEIGHT = 320,
   parameter int WIDTH  = 240
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        find_corners_flag,
   input  logic [7:0]  x_center,
   input  logic [8:0]  y_center,
   input  logic        pixel_data_in,
   output logic [16:0] addr_out,
   output logic        data_valid_out,
   output logic [7:0]  right_edge,
   output logic [7:0]  left_edge,
   output logic [8:0]  top_edge,
   output logic [8:0]  bot_edge
);
   // state  | meaning
   // IDLE   | waiting for find_corners_flag
   // SCAN_R | stepping +x along the centre row
   // SCAN_L | stepping -x along the centre row
   // SCAN_U | stepping -y along the centre column
   // SCAN_D | stepping +y along the centre column
   // DONE   | data_valid_out high for this one cycle
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SCAN_R = 3'd1;
   localparam logic [2:0] SCAN_L = 3'd2;
   localparam logic [2:0] SCAN_U = 3'd3;
   localparam logic [2:0] SCAN_D = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;

`ifdef EDGES_DEBOUNCE_EN
   localparam logic DEBOUNCE = 1'b1;
`else
   localparam logic DEBOUNCE = 1'b0;
`endif

   localparam logic [8:0] BOUND_R = 9'(WIDTH - 1);
   localparam logic [8:0] BOUND_D = 9'(HEIGHT - 1);

   logic [2:0]  state;
   logic [7:0]  cx;
   logic [8:0]  cy;
   logic [8:0]  pos;
   logic [8:0]  last_one;
   logic        zero_seen;
   logic        issuing;
   logic        tag0_v, tag0_last, tag1_v, tag1_last;
   logic [8:0]  tag0_pos, tag1_pos;

   logic        scanning, horiz, inc, at_bound, hit_zero, finish;
   logic [8:0]  bound, pos_next, ny, edge_val, next_centre;
   logic [7:0]  nx;
   logic [16:0] addr_next;

   always_comb begin
      scanning    = (state == SCAN_R) || (state == SCAN_L) || (state == SCAN_U) || (state == SCAN_D);
      horiz       = (state == SCAN_R) || (state == SCAN_L);
      inc         = (state == SCAN_R) || (state == SCAN_D);
      bound       = 9'd0;
      if (state == SCAN_R) bound = BOUND_R;
      if (state == SCAN_D) bound = BOUND_D;
      at_bound    = inc ? (pos >= bound) : (pos == 9'd0);
      pos_next    = inc ? pos + 9'd1 : pos - 9'd1;
      nx          = horiz ? pos_next[7:0] : cx;
      ny          = horiz ? cy : pos_next;
      addr_next   = 17'(ny) * 17'(WIDTH) + 17'(nx);
      hit_zero    = tag1_v && !pixel_data_in && (zero_seen || !DEBOUNCE);
      finish      = scanning && ((issuing && at_bound) || hit_zero || (tag1_v && tag1_last));
      // last_one already holds the centre or the most recent card pixel, so only
      // a card pixel at the image border overrides it.
      edge_val    = (tag1_v && tag1_last && pixel_data_in) ? tag1_pos : last_one;
      next_centre = (state == SCAN_R) ? {1'b0, cx} : cy;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state          <= IDLE;
         cx             <= '0;
         cy             <= '0;
         pos            <= '0;
         last_one       <= '0;
         zero_seen      <= 1'b0;
         issuing        <= 1'b0;
         tag0_v         <= 1'b0;
         tag0_last      <= 1'b0;
         tag0_pos       <= '0;
         tag1_v         <= 1'b0;
         tag1_last      <= 1'b0;
         tag1_pos       <= '0;
         addr_out       <= '0;
         data_valid_out <= 1'b0;
         right_edge     <= '0;
         left_edge      <= '0;
         top_edge       <= '0;
         bot_edge       <= '0;
      end else begin
         data_valid_out <= 1'b0;
         case (state)
            IDLE: begin
               if (find_corners_flag) begin
                  cx        <= x_center;
                  cy        <= y_center;
                  pos       <= {1'b0, x_center};
                  last_one  <= {1'b0, x_center};
                  zero_seen <= 1'b0;
                  issuing   <= 1'b1;
                  tag0_v    <= 1'b0;
                  tag1_v    <= 1'b0;
                  state     <= SCAN_R;
               end
            end
            DONE: state <= IDLE;
            SCAN_R, SCAN_L, SCAN_U, SCAN_D: begin
               if (finish) begin
                  case (state)
                     SCAN_R: begin right_edge <= edge_val[7:0]; state <= SCAN_L; end
                     SCAN_L: begin left_edge  <= edge_val[7:0]; state <= SCAN_U; end
                     SCAN_U: begin top_edge   <= edge_val;      state <= SCAN_D; end
                     default: begin
                        bot_edge       <= edge_val;
                        state          <= DONE;
                        data_valid_out <= 1'b1;
                     end
                  endcase
                  pos       <= next_centre;
                  last_one  <= next_centre;
                  zero_seen <= 1'b0;
                  issuing   <= (state != SCAN_D);
                  tag0_v    <= 1'b0;
                  tag1_v    <= 1'b0;
               end else begin
                  tag1_v    <= tag0_v;
                  tag1_last <= tag0_last;
                  tag1_pos  <= tag0_pos;
                  if (issuing) begin
                     addr_out  <= addr_next;
                     tag0_v    <= 1'b1;
                     tag0_pos  <= pos_next;
                     tag0_last <= (pos_next == bound);
                     pos       <= pos_next;
                     issuing   <= (pos_next != bound);
                  end else begin
                     tag0_v <= 1'b0;
                  end
                  if (tag1_v) begin
                     if (pixel_data_in) begin
                        last_one  <= tag1_pos;
                        zero_seen <= 1'b0;
                     end else begin
                        zero_seen <= 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_card_edges.sv
// Scoreboard bench for card_edges: a frame-buffer model feeds pixels, a loop-based
// reference predicts the edges, and a monitor checks each data_valid_out pulse.
module tb_card_edges;
   localparam int W = 240;
   localparam int H = 320;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        find_corners_flag;
   logic [7:0]  x_center;
   logic [8:0]  y_center;
   logic        pixel_data_in = 1'b0;
   logic [16:0] addr_out;
   logic        data_valid_out;
   logic [7:0]  right_edge, left_edge;
   logic [8:0]  top_edge, bot_edge;

   card_edges #(.HEIGHT(H), .WIDTH(W)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .find_corners_flag(find_corners_flag),
      .x_center(x_center), .y_center(y_center), .pixel_data_in(pixel_data_in),
      .addr_out(addr_out), .data_valid_out(data_valid_out),
      .right_edge(right_edge), .left_edge(left_edge), .top_edge(top_edge), .bot_edge(bot_edge)
   );

   always #5 clk_in = ~clk_in;

   bit mem [0:W*H-1];
   int cyc = 0;
   int vectors = 0;
   int errors = 0;

   typedef struct {int r; int l; int t; int b; int t0;} exp_t;
   exp_t q[$];
   exp_t last_exp;

   always @(posedge clk_in) cyc <= cyc + 1;
   always @(posedge clk_in) pixel_data_in <= (int'(addr_out) < W*H) ? mem[addr_out] : 1'b0;

   task automatic check(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   always @(negedge clk_in) begin
      if (!rst_in && int'(addr_out) >= W*H) begin
         errors++;
         $display("FAIL addr_range: got %0d, expected below %0d", addr_out, W*H);
      end
      if (data_valid_out) begin
         if (q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_valid: got pulse at cycle %0d, expected none", cyc);
         end else begin
            exp_t e;
            int lat, limit;
            e = q.pop_front();
            check("right_edge", int'(right_edge), e.r);
            check("left_edge",  int'(left_edge),  e.l);
            check("top_edge",   int'(top_edge),   e.t);
            check("bot_edge",   int'(bot_edge),   e.b);
            lat   = cyc - e.t0;
            limit = (e.r - e.l) + (e.b - e.t) + 20;
            vectors++;
            if (lat > limit) begin
               errors++;
               $display("FAIL latency: got %0d cycles, limit %0d", lat, limit);
            end
         end
      end
   end

   function automatic bit in_img(input int x, input int y);
      return x >= 0 && x < W && y >= 0 && y < H;
   endfunction

   // Walk outward from the centre over the image array and return the last card coordinate.
   function automatic int scan_dir(input int cx, input int cy, input int dx, input int dy);
      int x, y, last;
      bit stop;
      x = cx; y = cy;
      last = (dx != 0) ? cx : cy;
      stop = 1'b0;
      while (!stop && in_img(x + dx, y + dy)) begin
         x += dx; y += dy;
         if (mem[y*W + x]) last = (dx != 0) ? x : y;
         else begin
`ifdef EDGES_DEBOUNCE_EN
            if (!in_img(x + dx, y + dy) || !mem[(y + dy)*W + x + dx]) stop = 1'b1;
`else
            stop = 1'b1;
`endif
         end
      end
      return last;
   endfunction

   task automatic set_card(input int x0, input int x1, input int y0, input int y1);
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            mem[y*W + x] = (x >= x0 && x <= x1 && y >= y0 && y <= y1);
   endtask

   task automatic start_scan(input int x, input int y);
      exp_t e;
      e.r = scan_dir(x, y, 1, 0);
      e.l = scan_dir(x, y, -1, 0);
      e.t = scan_dir(x, y, 0, -1);
      e.b = scan_dir(x, y, 0, 1);
      @(negedge clk_in);
      e.t0 = cyc + 1;
      q.push_back(e);
      last_exp = e;
      find_corners_flag = 1'b1;
      x_center = 8'(x);
      y_center = 9'(y);
      @(negedge clk_in);
      find_corners_flag = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (q.size() != 0 && n < 1500) begin
         @(posedge clk_in);
         n++;
      end
      vectors++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scan_timeout: got no valid after %0d cycles, expected one", n);
         q.delete();
      end
      repeat (2) @(negedge clk_in);
   endtask

   task automatic run(input int x, input int y);
      start_scan(x, y);
      wait_done();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish, expected end of run");
      $fatal(1, "watchdog");
   end

   initial begin
      int x0, x1, y0, y1, cx, cy, nh, hx, hy;
      rst_in = 1'b0;
      find_corners_flag = 1'b0;
      x_center = '0;
      y_center = '0;
      set_card(40, 190, 30, 290);
      #3 rst_in = 1'b1;
      #2;
      check("reset_addr",  int'(addr_out),       0);
      check("reset_valid", int'(data_valid_out), 0);
      check("reset_right", int'(right_edge),     0);
      check("reset_left",  int'(left_edge),      0);
      check("reset_top",   int'(top_edge),       0);
      check("reset_bot",   int'(bot_edge),       0);
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;
      repeat (2) @(negedge clk_in);

      run(114, 153);
      repeat (5) @(negedge clk_in);
      check("hold_right", int'(right_edge), last_exp.r);
      check("hold_bot",   int'(bot_edge),   last_exp.b);

      set_card(0, W-1, 0, H-1);
      run(114, 153);
      run(0, 0);
      run(W-1, H-1);

      set_card(40, 190, 30, 290);
      mem[153*W + 115] = 1'b0;
      run(114, 153);

      set_card(40, 190, 30, 290);
      mem[153*W + 150] = 1'b0;
      run(114, 153);

      // reset in the middle of a scan: outputs clear at once and the pulse never comes
      set_card(40, 190, 30, 290);
      start_scan(114, 153);
      repeat (50) @(posedge clk_in);
      #2 rst_in = 1'b1;
      #1;
      q.delete();
      check("abort_addr",  int'(addr_out),       0);
      check("abort_valid", int'(data_valid_out), 0);
      check("abort_right", int'(right_edge),     0);
      check("abort_left",  int'(left_edge),      0);
      check("abort_top",   int'(top_edge),       0);
      check("abort_bot",   int'(bot_edge),       0);
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;
      repeat (20) @(negedge clk_in);
      run(114, 153);

      // a start pulse while busy must not spawn a second result
      start_scan(114, 153);
      repeat (30) @(negedge clk_in);
      find_corners_flag = 1'b1;
      x_center = 8'd60;
      y_center = 9'd60;
      @(negedge clk_in);
      find_corners_flag = 1'b0;
      wait_done();
      repeat (20) @(negedge clk_in);

      for (int it = 0; it < 25; it++) begin
         x0 = $urandom_range(0, 110);
         x1 = $urandom_range(130, W-1);
         y0 = $urandom_range(0, 150);
         y1 = $urandom_range(170, H-1);
         cx = $urandom_range(x0, x1);
         cy = $urandom_range(y0, y1);
         set_card(x0, x1, y0, y1);
         nh = $urandom_range(0, 4);
         for (int k = 0; k < nh; k++) begin
            if ($urandom_range(0, 1) == 1) begin
               hx = $urandom_range(x0, x1);
               if (hx != cx) mem[cy*W + hx] = 1'b0;
               if ($urandom_range(0, 1) == 1 && hx + 1 <= x1 && hx + 1 != cx) mem[cy*W + hx + 1] = 1'b0;
            end else begin
               hy = $urandom_range(y0, y1);
               if (hy != cy) mem[hy*W + cx] = 1'b0;
               if ($urandom_range(0, 1) == 1 && hy + 1 <= y1 && hy + 1 != cy) mem[(hy + 1)*W + cx] = 1'b0;
            end
         end
         run(cx, cy);
      end

      repeat (10) @(negedge clk_in);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
